count_enable_ctrl: RTL and testbench
====================================

# count_enable_ctrl

Upstream control stage for the 5-bit T-flip-flop ripple counter. It turns a raw, bouncing run/pause pushbutton into the counter's `T` enable. The button is synchronised and debounced, and each clean press toggles `T` between pause (0) and count (1). An optional single-step button issues exactly one count-enable cycle while the counter is paused.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive identical synchronised samples required to accept a button level change. Legal range is 2..65535.
- `DB_W`, default derived as clog2(`DEBOUNCE_CYCLES`): debounce counter width. Not overridden by users.

Ports:
- `clock`, input, 1: single system clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous reset, active-high.
- `btn_run`, input, 1: raw run/pause pushbutton, asynchronous, active-high.
- `btn_step`, input, 1: raw single-step pushbutton, asynchronous, active-high. Present only with `COUNT_STEP_EN`.
- `T`, output, 1: count enable to the ripple counter.
- `running`, output, 1: registered run/pause state.
- `step_pulse`, output, 1: one-cycle step strobe. Present only with `COUNT_STEP_EN`.

## Operation
- Each button path is a 2-flop synchroniser followed by a debouncer, then a rising-edge detector on the debounced level.
- Debouncer counter behaviour:
  - Clears whenever the synchronised sample equals the stable level.
  - Increments on each mismatching sample.
  - On the `DEBOUNCE_CYCLES`-th consecutive mismatch, the stable level flips and the counter clears.
  - Any bounce back to the stable level before that point restarts the count from 0.
- Run/pause FSM, states `PAUSED` and `RUNNING`:
  - `PAUSED` moves to `RUNNING` on a debounced rising edge of `btn_run`.
  - `RUNNING` moves to `PAUSED` on a debounced rising edge of `btn_run`.
  - The falling edge of the button has no effect.
  - Holding the button produces a single toggle.
- `running` is 1 in `RUNNING`, 0 in `PAUSED`.
- Step (with `COUNT_STEP_EN`):
  - A debounced rising edge of `btn_step` while in `PAUSED` sets `step_pulse` = 1 for exactly one cycle.
  - The step edge is ignored in `RUNNING`.
- Simultaneous run edge and step edge in the same cycle: the run toggle is taken and the step is discarded.
- Reset values: `T` = 0, `running` = 0, `step_pulse` = 0. Synchronisers, stable levels and debounce counters all reset to 0.
- Reset mid-debounce discards the partial count. A button held through reset release is seen as a new press after the full debounce latency.

## Timing
- `btn_run` rises before edge 0 and stays clean:
  - The synchroniser output reflects it at edge 1.
  - The stable level flips at edge `DEBOUNCE_CYCLES`+1.
  - `running` and `T` change at edge `DEBOUNCE_CYCLES`+2.
  - With the default, latency is 18 edges.
- `step_pulse` follows the same latency and is high for one cycle only.
- `T` is registered and glitch-free. It never changes except at a `clock` edge.
- Back-to-back accepted presses need a release that is itself debounced, so the minimum press-to-press spacing is 2×`DEBOUNCE_CYCLES` cycles.

## Configuration
- `COUNT_STEP_EN` defined:
  - `btn_step` and `step_pulse` exist.
  - `T` = `running` OR `step_pulse`.
- `COUNT_STEP_EN` undefined:
  - Step ports and logic are absent.
  - `T` = `running`.

## Structure
- Shared package `count_ctrl_pkg` holds:
  - the run-state encoding constants (`PAUSED` = 0, `RUNNING` = 1);
  - the clog2 helper function used for `DB_W`;
  - the default `DEBOUNCE_CYCLES` constant.
- Sub-module `btn_debounce` (synchroniser, counter, stable level, rise strobe) is instantiated once per button.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES` = 4.
- Reset held 3 cycles with `btn_run` = 1 → `T` = 0 and `running` = 0 during reset. After release, `T` rises exactly 6 edges later.
- Clean `btn_run` press held 10 cycles → `T` goes 0→1 once, 6 edges after the press, and stays 1 after release. A second press returns `T` to 0.
- `btn_run` bounce pattern 1,0,1,0,1,1,1,1 → no toggle until the final 4 consecutive 1s are seen. Exactly one toggle results.
- `btn_run` glitch of 3 cycles high → `T` is unchanged.
- `COUNT_STEP_EN`, paused, `btn_step` pressed → `T` = 1 for exactly 1 cycle, so the downstream counter advances by 1. The same press while running leaves `T` = 1 with no extra pulse.
- `COUNT_STEP_EN`, `btn_run` and `btn_step` pressed on the same cycle while paused → `running` = 1 and `step_pulse` never asserts.

Source files
------------

// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg
//   Shared constants for the counter enable control stage:
//   - run-state encoding (PAUSED / RUNNING)
//   - clog2 helper used to size the debounce counter
//   - default debounce length
package count_ctrl_pkg;

    localparam logic [0:0] PAUSED  = 1'b0;
    localparam logic [0:0] RUNNING = 1'b1;

    localparam int DEBOUNCE_DEFAULT = 16;

    // Bits needed to hold values 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if (((v - 1) >> i) != 0) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
//   One pushbutton path: 2-flop synchroniser, debounce counter with a
//   stable level, and a one-cycle strobe on the stable level's rising edge.
// Ports:
//   clock   - system clock, rising edge
//   reset   - synchronous, active-high
//   btn     - raw asynchronous button level
//   rise    - high for one cycle after the debounced level goes 0->1
module btn_debounce
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DB_W            = clog2(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic            sync1;
    logic            sync2;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            // cnt holds the number of mismatches already seen; the current
            // mismatch is the DEBOUNCE_CYCLES-th when cnt reaches N-1.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= ~stable;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/count_enable_ctrl.sv
// count_enable_ctrl
//   Run/pause control for the 5-bit T-flip-flop ripple counter. A debounced
//   run button toggles between PAUSED and RUNNING; T is the count enable.
//   Optional feature macro: COUNT_STEP_EN adds a single-step button that
//   issues one enable cycle while paused.
// Ports:
//   clock      - system clock, rising edge
//   reset      - synchronous, active-high
//   btn_run    - raw run/pause button
//   btn_step   - raw single-step button (COUNT_STEP_EN only)
//   T          - registered count enable
//   running    - registered run state
//   step_pulse - one-cycle step strobe (COUNT_STEP_EN only)
module count_enable_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int DB_W            = clog2(DEBOUNCE_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_run,
`ifdef COUNT_STEP_EN
    input  logic btn_step,
    output logic step_pulse,
`endif
    output logic T,
    output logic running
);

    logic       run_rise;
    logic [0:0] state;
    logic [0:0] state_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_run (
        .clock (clock),
        .reset (reset),
        .btn   (btn_run),
        .rise  (run_rise)
    );

    always_comb begin
        state_next = state;
        if (run_rise) state_next = (state == PAUSED) ? RUNNING : PAUSED;
    end

`ifdef COUNT_STEP_EN
    logic step_rise;
    logic step_next;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .DB_W(DB_W)) u_step (
        .clock (clock),
        .reset (reset),
        .btn   (btn_step),
        .rise  (step_rise)
    );

    // A run toggle in the same cycle wins; the step is dropped.
    assign step_next = step_rise & (state == PAUSED) & ~run_rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= PAUSED;
            step_pulse <= 1'b0;
            T          <= 1'b0;
        end else begin
            state      <= state_next;
            step_pulse <= step_next;
            // T comes straight from a flop so the counter never sees a glitch.
            T          <= (state_next == RUNNING) | step_next;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= PAUSED;
            T     <= 1'b0;
        end else begin
            state <= state_next;
            T     <= (state_next == RUNNING);
        end
    end
`endif

    assign running = (state == RUNNING);

endmodule

// File: tb/tb_count_enable_ctrl.sv
// tb_count_enable_ctrl
//   Self-checking bench: directed scenarios with literal expectations plus a
//   randomized phase, all cross-checked every cycle against a behavioural
//   model built from sample histories. Works with or without COUNT_STEP_EN.
module tb_count_enable_ctrl;

    localparam int N = 4;

    logic clock    = 1'b0;
    logic reset    = 1'b1;
    logic btn_run  = 1'b0;
    logic btn_step = 1'b0;
    logic T;
    logic running;
`ifdef COUNT_STEP_EN
    logic step_pulse;
`endif

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clock = ~clock;

    count_enable_ctrl #(.DEBOUNCE_CYCLES(N)) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_run    (btn_run),
`ifdef COUNT_STEP_EN
        .btn_step   (btn_step),
        .step_pulse (step_pulse),
`endif
        .T          (T),
        .running    (running)
    );

    // ---------------- behavioural model ----------------
    // Each button: value seen by the debouncer lags the raw pin by two edges.
    // The stable level flips once the last N samples since the previous flip
    // all disagree with it. A flip to 1 acts on the run/step state one edge later.
    bit ms1r, ms2r, ms1s, ms2s, mstr, msts, mrp, msp_pend, mrun, msp;
    bit hr[$];
    bit hs[$];

    function automatic bit settled(input bit q[$], input bit lvl);
        if (q.size() < N) return 1'b0;
        foreach (q[i]) if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clock) begin
        bit rr, rs, orun, sin;
`ifdef COUNT_STEP_EN
        sin = btn_step;
`else
        sin = 1'b0;
`endif
        if (reset) begin
            ms1r = 0; ms2r = 0; ms1s = 0; ms2s = 0; mstr = 0; msts = 0;
            mrp = 0; msp_pend = 0; mrun = 0; msp = 0;
            hr.delete(); hs.delete();
        end else begin
            hr.push_back(ms2r); if (hr.size() > N) void'(hr.pop_front());
            hs.push_back(ms2s); if (hs.size() > N) void'(hs.pop_front());
            ms2r = ms1r; ms1r = btn_run;
            ms2s = ms1s; ms1s = sin;
            rr = 0; rs = 0;
            if (settled(hr, mstr)) begin mstr = ~mstr; hr.delete(); rr = mstr; end
            if (settled(hs, msts)) begin msts = ~msts; hs.delete(); rs = msts; end
            orun = mrun;
            if (mrp) mrun = ~mrun;
            msp = msp_pend & ~orun & ~mrp;
            mrp = rr;
            msp_pend = rs;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clock) begin
        if (chk_en) begin
            checks++;
            if (T !== (mrun | msp)) begin
                failures++;
                $display("FAIL model_T t=%0t actual=%b expected=%b", $time, T, mrun | msp);
            end
            checks++;
            if (running !== mrun) begin
                failures++;
                $display("FAIL model_running t=%0t actual=%b expected=%b", $time, running, mrun);
            end
`ifdef COUNT_STEP_EN
            checks++;
            if (step_pulse !== msp) begin
                failures++;
                $display("FAIL model_step t=%0t actual=%b expected=%b", $time, step_pulse, msp);
            end
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Called just after a negedge. Bit i of pat is driven before edge i.
    // Reports the edge index of the first running change, number of running
    // changes, cycles with T high and cycles with step_pulse high.
    task automatic drive_obs(input logic [31:0] pat, input int ncyc,
                             input bit use_run, input bit use_step,
                             output int first, output int tog,
                             output int thigh, output int sp);
        logic [31:0] p;
        logic        prev;
        p = pat;
        first = -1; tog = 0; thigh = 0; sp = 0;
        prev = running;
        for (int i = 0; i < ncyc; i++) begin
            btn_run = use_run ? p[i] : 1'b0;
`ifdef COUNT_STEP_EN
            btn_step = use_step ? p[i] : 1'b0;
`endif
            @(posedge clock); #1;
            if (running !== prev) begin
                tog++;
                if (first < 0) first = i;
            end
            prev = running;
            if (T === 1'b1) thigh++;
`ifdef COUNT_STEP_EN
            if (step_pulse === 1'b1) sp++;
`endif
            @(negedge clock);
        end
        btn_run = 1'b0;
        btn_step = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int f, tg, th, sp, hold_r, hold_s, rst_left;

        // Reset held with btn_run high.
        reset = 1'b1; btn_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("reset_T", int'(T), 0);
            chk("reset_running", int'(running), 0);
        end
        @(negedge clock);
        reset = 1'b0;
        chk_en = 1'b1;
        // Edge 0 is the first edge after release; T must rise at edge N+2.
        drive_obs(32'h3FF, 24, 1, 0, f, tg, th, sp);
        chk("rst_release_edge", f, 6);
        chk("rst_release_toggles", tg, 1);
        chk("rst_release_running", int'(running), 1);

        // Clean press: back to paused, then running again.
        drive_obs(32'h3FF, 24, 1, 0, f, tg, th, sp);
        chk("press2_edge", f, 6);
        chk("press2_toggles", tg, 1);
        chk("press2_T", int'(T), 0);
        drive_obs(32'h3FF, 24, 1, 0, f, tg, th, sp);
        chk("press3_edge", f, 6);
        chk("press3_T", int'(T), 1);

        // Bounce 1,0,1,0 then steady 1 from index 4: toggle at edge 4+6.
        drive_obs(32'h3F5, 28, 1, 0, f, tg, th, sp);
        chk("bounce_edge", f, 10);
        chk("bounce_toggles", tg, 1);
        chk("bounce_running", int'(running), 0);

        // Three-cycle glitch is shorter than the debounce window.
        drive_obs(32'h7, 16, 1, 0, f, tg, th, sp);
        chk("glitch_toggles", tg, 0);
        chk("glitch_T", int'(T), 0);

`ifdef COUNT_STEP_EN
        // Step while paused: one enable cycle.
        drive_obs(32'h3FF, 24, 0, 1, f, tg, th, sp);
        chk("step_paused_pulses", sp, 1);
        chk("step_paused_T_cycles", th, 1);
        chk("step_paused_toggles", tg, 0);
        drive_obs(32'h3FF, 24, 1, 0, f, tg, th, sp);
        chk("run_for_step_running", int'(running), 1);
        // Step while running: ignored, T stays high.
        drive_obs(32'h3FF, 24, 0, 1, f, tg, th, sp);
        chk("step_running_pulses", sp, 0);
        chk("step_running_T_cycles", th, 24);
        drive_obs(32'h3FF, 24, 1, 0, f, tg, th, sp);
        chk("pause_again_running", int'(running), 0);
        // Both buttons together while paused: run wins, no step.
        drive_obs(32'h3FF, 24, 1, 1, f, tg, th, sp);
        chk("both_running", int'(running), 1);
        chk("both_pulses", sp, 0);
        chk("both_toggles", tg, 1);
`endif

        // Randomized phase: random levels held for random lengths, rare resets.
        hold_r = 0; hold_s = 0; rst_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold_r == 0) begin
                btn_run = 1'($urandom_range(0, 1));
                hold_r = $urandom_range(1, 2 * N + 4);
            end
            hold_r--;
`ifdef COUNT_STEP_EN
            if (hold_s == 0) begin
                btn_step = 1'($urandom_range(0, 1));
                hold_s = $urandom_range(1, 2 * N + 4);
            end
            hold_s--;
`endif
            if (rst_left > 0) rst_left--;
            else if ($urandom_range(0, 199) == 0) rst_left = $urandom_range(1, 3);
            reset = (rst_left > 0);
            @(negedge clock);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
